// File: rtl/axil_regfile_pkg.sv
// Shared response codes and handshake state types for the AXI-Lite register file.
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axil_regfile_if.sv
// AXI-Lite style bus bundle between a master and the register file.
interface axil_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0]   waddr;
  logic                    wavalid;
  logic                    waready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              wresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output waddr, wavalid, wdata, wstrb, wvalid, bready, raddr, arvalid, rready,
    input  waready, wready, wresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  waddr, wavalid, wdata, wstrb, wvalid, bready, raddr, arvalid, rready,
    output waready, wready, wresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_regfile_bank.sv
// Register storage with byte-strobe updates; read-only slots never store and show 0.
module axil_regfile_bank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter int                  IDX_W      = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  output logic                           wr_ok,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

  // Kept apart from the update logic so the FSM can use it without a combinational loop.
  always_comb begin
    wr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i) && !RO_MASK[i]) wr_ok = 1'b1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) mem_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : mem_q[i];
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// AXI-Lite register file: independent write and read handshake FSMs around a register bank.
//   state   | meaning
//   WR_IDLE | accepting AW and W independently; commit once both are held
//   WR_RESP | write response presented, waiting for bready
//   RD_IDLE | accepting AR
//   RD_DATA | read data presented, waiting for rready
module axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 6,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axil_regfile_if.slave                  s,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_d
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            wresp_q, wresp_d;

  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_fire, w_fire, commit, wr_ok;
  logic [IDX_W-1:0]      cm_idx, rd_idx;
  logic [DATA_WIDTH-1:0] cm_data, rd_word;
  logic [STRB_W-1:0]     cm_strb;
  logic                  rd_hit;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s.waddr[LSB-1:0], s.raddr[LSB-1:0]};

  assign s.waready = (wr_state_q == WR_IDLE) && !aw_held_q;
  assign s.wready  = (wr_state_q == WR_IDLE) && !w_held_q;
  assign s.bvalid  = (wr_state_q == WR_RESP);
  assign s.wresp   = wresp_q;
  assign s.arready = (rd_state_q == RD_IDLE);
  assign s.rvalid  = (rd_state_q == RD_DATA);
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

  assign aw_fire = s.wavalid && s.waready;
  assign w_fire  = s.wvalid && s.wready;

  // Commit operands: a held beat wins, otherwise the beat arriving this cycle.
  assign cm_idx  = aw_held_q ? awidx_q : s.waddr[ADDR_WIDTH-1:LSB];
  assign cm_data = w_held_q ? wdata_q : s.wdata;
  assign cm_strb = w_held_q ? wstrb_q : s.wstrb;

  axil_regfile_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .RO_MASK    (RO_MASK)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (commit),
    .wr_idx  (cm_idx),
    .wr_data (cm_data),
    .wr_strb (cm_strb),
    .wr_ok   (wr_ok),
    .reg_q   (reg_q)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wresp_d    = wresp_q;
    commit     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awidx_d   = s.waddr[ADDR_WIDTH-1:LSB];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s.wdata;
          wstrb_d  = s.wstrb;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          commit     = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: if (s.bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign rd_idx = s.raddr[ADDR_WIDTH-1:LSB];

  // RO slots come straight from hw_d; unmatched indices leave rd_word at 0.
  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_word = RO_MASK[i] ? hw_d[i*DATA_WIDTH +: DATA_WIDTH]
                             : reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s.arvalid) begin
          rdata_d    = rd_word;
          rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: if (s.rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wresp_q    <= '0;
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wresp_q    <= wresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Drives two register files (all-RW and RO_MASK=0x02) in lockstep against a scoreboard model.
module tb_axil_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wavalid, wvalid, bready, arvalid, rready;
  logic [255:0] reg_q0, reg_q1, hw_d;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [2][8];
  logic [7:0]  ro_mask [2];
  logic [1:0]  exp_b0[$], exp_b1[$];
  logic [33:0] exp_r0[$], exp_r1[$];

  always #5 clk = ~clk;

  axil_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus0 ();
  axil_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus1 ();

  assign bus0.waddr = waddr;   assign bus1.waddr = waddr;
  assign bus0.wavalid = wavalid; assign bus1.wavalid = wavalid;
  assign bus0.wdata = wdata;   assign bus1.wdata = wdata;
  assign bus0.wstrb = wstrb;   assign bus1.wstrb = wstrb;
  assign bus0.wvalid = wvalid; assign bus1.wvalid = wvalid;
  assign bus0.bready = bready; assign bus1.bready = bready;
  assign bus0.raddr = raddr;   assign bus1.raddr = raddr;
  assign bus0.arvalid = arvalid; assign bus1.arvalid = arvalid;
  assign bus0.rready = rready; assign bus1.rready = rready;

  axil_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(8), .RO_MASK(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .s(bus0.slave), .reg_q(reg_q0), .hw_d(hw_d));
  axil_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(8), .RO_MASK(8'h02)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(bus1.slave), .reg_q(reg_q1), .hw_d(hw_d));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_write(int k, logic [5:0] a, logic [31:0] d, logic [3:0] st);
    int idx;
    idx = int'(a >> 2);
    if (idx >= 8 || ro_mask[k][idx]) return 2'b10;
    for (int b = 0; b < 4; b++) if (st[b]) m[k][idx][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(int k, logic [5:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx >= 8) return {2'b10, 32'h0};
    if (ro_mask[k][idx]) return {2'b00, hw_d[idx*32 +: 32]};
    return {2'b00, m[k][idx]};
  endfunction

  function automatic logic [255:0] model_regq(int k);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = ro_mask[k][i] ? 32'h0 : m[k][i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m[k][i] = 32'h0;
  endfunction

  function automatic void push_write(logic [5:0] a, logic [31:0] d, logic [3:0] st);
    exp_b0.push_back(model_write(0, a, d, st));
    exp_b1.push_back(model_write(1, a, d, st));
  endfunction

  function automatic void push_read(logic [5:0] a);
    exp_r0.push_back(model_read(0, a));
    exp_r1.push_back(model_read(1, a));
  endfunction

  task automatic check_b(input string tag);
    logic [1:0] e0, e1;
    e0 = (exp_b0.size() != 0) ? exp_b0.pop_front() : 2'bxx;
    e1 = (exp_b1.size() != 0) ? exp_b1.pop_front() : 2'bxx;
    chk({tag, " wresp0"}, bus0.wresp, e0);
    chk({tag, " wresp1"}, bus1.wresp, e1);
  endtask

  task automatic check_r(input string tag);
    logic [33:0] e0, e1;
    e0 = (exp_r0.size() != 0) ? exp_r0.pop_front() : 34'bx;
    e1 = (exp_r1.size() != 0) ? exp_r1.pop_front() : 34'bx;
    chk({tag, " rd0"}, {bus0.rresp, bus0.rdata}, e0);
    chk({tag, " rd1"}, {bus1.rresp, bus1.rdata}, e1);
  endtask

  task automatic do_write(input string tag, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_acc, w_acc;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    push_write(a, d, st);
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      waddr = a; wdata = d; wstrb = st;
      wavalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      #1;
      aw_acc = wavalid && bus0.waready;
      w_acc  = wvalid && bus0.wready;
      @(posedge clk);
      if (aw_acc) aw_done = 1;
      if (w_acc)  w_done = 1;
      cyc++;
    end
    @(negedge clk);
    wavalid = 0; wvalid = 0;
    chk({tag, " accept"}, {aw_done, w_done}, 2'b11);
    chk({tag, " bvalid0"}, bus0.bvalid, 1'b1);
    chk({tag, " bvalid1"}, bus1.bvalid, 1'b1);
    check_b(tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " bvalid drop"}, bus0.bvalid, 1'b0);
    chk({tag, " reg_q0"}, reg_q0, model_regq(0));
    chk({tag, " reg_q1"}, reg_q1, model_regq(1));
  endtask

  task automatic do_read(input string tag, input logic [5:0] a);
    bit acc;
    int cyc;
    acc = 0; cyc = 0;
    push_read(a);
    while (!acc && cyc < 40) begin
      @(negedge clk);
      raddr = a; arvalid = 1;
      #1;
      acc = bus0.arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    arvalid = 0;
    chk({tag, " ar accept"}, acc, 1'b1);
    chk({tag, " rvalid0"}, bus0.rvalid, 1'b1);
    chk({tag, " rvalid1"}, bus1.rvalid, 1'b1);
    check_r(tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " rvalid drop"}, bus0.rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  st;

    waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
    wavalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    ro_mask[0] = 8'h00;
    ro_mask[1] = 8'h02;
    for (int i = 0; i < 8; i++) hw_d[i*32 +: 32] = (i == 1) ? 32'hCAFE0001 : (32'hA0A00000 | 32'(i));
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst bvalid", {bus0.bvalid, bus1.bvalid}, 2'b00);
    chk("rst rvalid", {bus0.rvalid, bus1.rvalid}, 2'b00);
    chk("rst resp", {bus0.wresp, bus0.rresp, bus1.wresp, bus1.rresp}, 8'h00);
    chk("rst rdata", {bus0.rdata, bus1.rdata}, 64'h0);
    chk("rst reg_q0", reg_q0, 256'h0);
    chk("rst reg_q1", reg_q1, 256'h0);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("post-rst readies", {bus0.waready, bus0.wready, bus0.arready}, 3'b111);

    // Same-cycle AW/W; dut1 sees register 1 as read-only
    do_write("w04", 6'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read("r04", 6'h04);

    // W first, AW three cycles later, partial strobe
    do_write("w00 full", 6'h00, 32'h12345678, 4'hF, 0, 0);
    do_write("w00 late aw", 6'h00, 32'h0000AAAA, 4'h3, 3, 0);
    do_read("r00", 6'h00);

    // AW first, W later, sparse strobe
    do_write("w08 late w", 6'h08, 32'h55667788, 4'b1010, 0, 2);
    do_read("r08", 6'h08);

    // Out of range
    do_write("w3c", 6'h3C, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_read("r3c", 6'h3C);
    do_read("r07 low bits", 6'h07);

    // AR on the same edge as a commit to the same register returns the old value
    @(negedge clk);
    waddr = 6'h00; wdata = 32'h0F0F0F0F; wstrb = 4'hF; wavalid = 1; wvalid = 1;
    raddr = 6'h00; arvalid = 1;
    push_read(6'h00);
    push_write(6'h00, 32'h0F0F0F0F, 4'hF);
    @(posedge clk);
    @(negedge clk);
    wavalid = 0; wvalid = 0; arvalid = 0;
    chk("same-edge bvalid", {bus0.bvalid, bus1.bvalid}, 2'b11);
    chk("same-edge rvalid", {bus0.rvalid, bus1.rvalid}, 2'b11);
    check_b("same-edge");
    check_r("same-edge");
    @(posedge clk);
    @(negedge clk);
    chk("same-edge reg_q0", reg_q0, model_regq(0));
    do_read("r00 after", 6'h00);

    // Backpressure on both responses; new requests must stay pending
    @(negedge clk);
    bready = 0; rready = 0;
    waddr = 6'h08; wdata = 32'h0BADF00D; wstrb = 4'hF; wavalid = 1; wvalid = 1;
    raddr = 6'h04; arvalid = 1;
    push_read(6'h04);
    push_write(6'h08, 32'h0BADF00D, 4'hF);
    @(posedge clk);
    @(negedge clk);
    waddr = 6'h0C; raddr = 6'h0C; wdata = 32'h11111111;
    begin
      logic [1:0]  eb0, eb1;
      logic [33:0] er0, er1;
      eb0 = exp_b0.pop_front(); eb1 = exp_b1.pop_front();
      er0 = exp_r0.pop_front(); er1 = exp_r1.pop_front();
      for (int c = 0; c < 5; c++) begin
        chk("hold valids", {bus0.bvalid, bus1.bvalid, bus0.rvalid, bus1.rvalid}, 4'hF);
        chk("hold wresp", {bus0.wresp, bus1.wresp}, {eb0, eb1});
        chk("hold rd0", {bus0.rresp, bus0.rdata}, er0);
        chk("hold rd1", {bus1.rresp, bus1.rdata}, er1);
        chk("hold readies", {bus0.waready, bus0.wready, bus0.arready}, 3'b000);
        @(posedge clk);
        @(negedge clk);
      end
    end
    wavalid = 0; wvalid = 0; arvalid = 0;
    bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("hold release", {bus0.bvalid, bus0.rvalid}, 2'b00);
    chk("hold reg_q0", reg_q0, model_regq(0));
    chk("hold reg_q1", reg_q1, model_regq(1));

    // Reset after AW accepted but before W
    @(negedge clk);
    waddr = 6'h08; wavalid = 1;
    @(posedge clk);
    @(negedge clk);
    wavalid = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("mid-rst bvalid", {bus0.bvalid, bus1.bvalid}, 2'b00);
    chk("mid-rst rdata", {bus0.rdata, bus1.rdata}, 64'h0);
    chk("mid-rst reg_q0", reg_q0, 256'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid-rst waready", bus0.waready, 1'b1);
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("mid-rst no commit bvalid", {bus0.bvalid, bus1.bvalid}, 2'b00);
    chk("mid-rst w held", bus0.wready, 1'b0);
    chk("mid-rst no commit reg_q0", reg_q0, 256'h0);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    do_write("w1c", 6'h1C, 32'h76543210, 4'hF, 1, 0);
    do_read("r1c", 6'h1F);

    // Randomised traffic including out-of-range indices 8 and 9
    for (int i = 0; i < 6; i++) begin
      a  = 6'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      d  = $urandom;
      st = 4'($urandom_range(0, 15));
      do_write("rnd w", a, d, st, $urandom_range(0, 2), $urandom_range(0, 2));
      do_read("rnd r", a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
AXIL_REGFILE -- requirements
Module: axil_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI-Lite data width; must be 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: byte address width.
REQ-003 SHALL have parameter NUM_REGS, default 8: register count; 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have parameter RO_MASK, default 0: NUM_REGS bits; bit i set = register i read-only, sourced from hw_d.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- waddr  in  ADDR_WIDTH  write address.
- wavalid  in  1 / waready  out  1  write-address handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wvalid  in  1 / wready  out  1  write-data handshake.
- wresp  out  2  write response.
- bvalid  out  1 / bready  in  1  write-response handshake.
- raddr  in  ADDR_WIDTH  read address.
- arvalid  in  1 / arready  out  1  read-address handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1 / rready  in  1  read-data handshake.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- hw_d  in  NUM_REGS*DATA_WIDTH  hardware values for RO registers; same packing as reg_q.

Function
REQ-006 Register index SHALL be addr >> log2(DATA_WIDTH/8); low address bits ignored; index >= NUM_REGS is out of range.
REQ-007 Write path SHALL have states WR_IDLE and WR_RESP.
REQ-008 In WR_IDLE, waready SHALL be 1 until an address is captured and wready SHALL be 1 until data is captured.
- AW and W capture independently, in any order or the same cycle.
REQ-009 At the clock edge where both are held, the block SHALL:
- commit the write
- enter WR_RESP with bvalid=1 on the next cycle.
- Minimum latency: AW+W handshake edge -> bvalid 1 cycle.
REQ-010 Commit SHALL update each byte lane whose wstrb bit is 1, for in-range RW registers only.
REQ-011 wresp SHALL be:
- 2'b00 OKAY for in-range RW writes.
- 2'b10 SLVERR for out-of-range or RO-register writes; no state changes.
REQ-012 In WR_RESP:
- waready=wready=0.
- bvalid and wresp held stable until bready=1.
- Returns to WR_IDLE at the edge where bvalid&bready.
REQ-013 Read path SHALL have states RD_IDLE (arready=1) and RD_DATA (arready=0, rvalid=1).
REQ-014 At the AR handshake edge, the block SHALL:
- capture rdata from the current contents: reg_q for RW registers, hw_d for RO registers.
- enter RD_DATA.
- Latency: AR handshake -> rvalid next cycle.
REQ-015 Out-of-range reads SHALL return rdata=0 and rresp=2'b10; otherwise rresp=2'b00.
REQ-016 rdata and rresp SHALL hold stable while rvalid=1 and rready=0; RD_DATA -> RD_IDLE on rvalid&rready.
REQ-017 Read and write paths SHALL run concurrently. An AR handshake on the same edge as a commit to the same register SHALL return the pre-write value.
REQ-018 reg_q SHALL reflect committed values from the cycle after commit. RO slots in reg_q SHALL read 0.

Reset
REQ-019 rst_n=0 SHALL asynchronously force:
- both FSMs to idle.
- all registers, reg_q, rdata, wresp, rresp to 0.
- bvalid=rvalid=0.
- held AW/W flags cleared.
REQ-020 Reset mid-transaction SHALL abort the transaction: partially captured AW/W is discarded and no commit occurs.
REQ-021 waready, wready and arready SHALL be 1 from the first cycle after rst_n deasserts.

Structure
REQ-022 Package axil_regfile_pkg SHALL hold:
- response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- write and read state enums.
REQ-023 Storage with byte-strobe update and RO masking SHALL be a sub-module axil_regfile_bank; handshake FSMs stay in axil_regfile.

Verification
REQ-024 Same-cycle AW=0x04 and W=0xDEADBEEF with wstrb=0xF -> bvalid next cycle, wresp=00; then read 0x04 -> rdata=0xDEADBEEF, rresp=00.
REQ-025 W first, AW three cycles later; wstrb=0x3, data 0x0000AAAA to register 0 holding 0x12345678 -> register reads 0x1234AAAA.
REQ-026 Write to 0x3C with NUM_REGS=8 -> wresp=10, reg_q unchanged; read 0x3C -> rdata=0, rresp=10.
REQ-027 RO_MASK=0x02, hw_d[1]=0xCAFE0001: write to 0x04 -> SLVERR; read 0x04 -> 0xCAFE0001.
REQ-028 Hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid, wresp, rdata stable; no new AW/AR accepted.
REQ-029 rst_n low after AW accepted but before W -> no commit, bvalid=0, waready=1 the cycle after release.
